dc_param_sequencer: RTL and testbench

//  Sequences the SAR-ADC-to-duty-cycle loading path. One start request runs three
//  ADC conversions and loads them in a fixed order: H_on (switch 00), L_on (01), DeadTime (10).
//  For each conversion it drives ADC_res, op, switch and a valid pulse into conc_logic.

---
 rtl/dc_param_sequencer_pkg.sv | 30 +++
 rtl/dc_param_sequencer_if.sv | 31 +++
 rtl/dc_param_sequencer_timer.sv | 32 +++
 rtl/dc_param_sequencer.sv | 110 +++++++++++
 tb/tb_dc_param_sequencer.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/dc_param_sequencer_pkg.sv
// Shared types and constants for the ADC-to-duty-cycle parameter load path.
// Latency: n/a (types only).
// Backpressure: n/a. The same enums and codes are used by conc_logic.
package dc_seq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CONV = 3'd1,
    WAIT = 3'd2,
    LOAD = 3'd3,
    HOLD = 3'd4,
    DONE = 3'd5,
    ERR  = 3'd6
  } state_t;

  localparam logic [2:0] OP0     = 3'b000;
  localparam logic [2:0] OP1     = 3'b001;
  localparam logic [2:0] OP2     = 3'b010;
  localparam logic [2:0] OP3     = 3'b011;
  localparam logic [2:0] OP4     = 3'b100;
  localparam logic [2:0] OP5     = 3'b101;
  localparam logic [2:0] OP6     = 3'b110;
  // Any op value of OP_FAIL makes conc_logic fall back to its default timings.
  localparam logic [2:0] OP_FAIL = 3'b111;

  localparam logic [1:0] SW_HON  = 2'b00;
  localparam logic [1:0] SW_LON  = 2'b01;
  localparam logic [1:0] SW_DT   = 2'b10;

endpackage

// File: rtl/dc_param_sequencer_if.sv
// Bundles the start/ADC handshake and the conc_logic load bus of the sequencer.
// Latency: n/a (wiring only).
// Backpressure: none. The ADC answers with a one-cycle adc_done pulse, and conc_logic takes one valid pulse per field.
//   master: sequencer view. It drives adc_start, ADC_res, op, switch, valid, busy, done and error.
//   slave : environment view. It drives start, op_cfg, adc_done and adc_data.
interface dc_param_sequencer_if #(
  parameter int ADC_width = 8
);
  logic                 start;
  logic [2:0]           op_cfg;
  logic                 adc_start;
  logic                 adc_done;
  logic [ADC_width-1:0] adc_data;
  logic [ADC_width-1:0] ADC_res;
  logic [2:0]           op;
  logic [1:0]           switch;
  logic                 valid;
  logic                 busy;
  logic                 done;
  logic                 error;

  modport master (
    input  start, op_cfg, adc_done, adc_data,
    output adc_start, ADC_res, op, switch, valid, busy, done, error
  );

  modport slave (
    output start, op_cfg, adc_done, adc_data,
    input  adc_start, ADC_res, op, switch, valid, busy, done, error
  );
endinterface

// File: rtl/dc_param_sequencer_timer.sv
// ADC conversion timeout counter. It is cleared while a conversion is requested and counts while the sequencer waits.
// Latency: o_expired is decoded from the count register, so it is valid in the cycle in which the count reaches TO_CYCLES.
// Backpressure: none. The count saturates at TO_CYCLES and holds there until the next clear.
//   clk, rst   : clock and asynchronous active-high reset
//   i_clear    : force the count to zero (takes priority over i_enable)
//   i_enable   : increment the count by one
//   o_expired  : the count equals TO_CYCLES
module dc_seq_timer #(
  parameter int TO_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);
  localparam int W = $clog2(TO_CYCLES + 1);

  logic [W-1:0] r_timer;

  assign o_expired = (r_timer == W'(TO_CYCLES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer <= '0;
    end else if (i_clear) begin
      r_timer <= '0;
    end else if (i_enable && !o_expired) begin
      r_timer <= r_timer + 1'b1;
    end
  end
endmodule

// File: rtl/dc_param_sequencer.sv
// Runs three SAR conversions per start request and loads the results into conc_logic in the order H_on, L_on, DeadTime.
// Latency: start to adc_start is 1 clk, adc_done to valid is 1 clk, valid to the next adc_start is 2 clk. With a zero-wait ADC, start to done is 13 clk.
// Backpressure: a start request while busy is dropped, and adc_done outside WAIT is ignored. A conversion that takes too long aborts through ERR.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : start/op_cfg/ADC handshake inputs and the conc_logic load outputs (master modport)
module dc_param_sequencer
  import dc_seq_pkg::*;
#(
  parameter int ADC_width = 8,
  parameter int TO_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  dc_param_sequencer_if.master  bus
);

  state_t               r_state,   w_state_nxt;
  logic [ADC_width-1:0] r_adc_res, w_adc_res_nxt;
  logic [2:0]           r_op,      w_op_nxt;
  logic [1:0]           r_switch,  w_switch_nxt;
  logic                 r_error,   w_error_nxt;
  logic                 w_expired;

  dc_seq_timer #(.TO_CYCLES(TO_CYCLES)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (r_state == CONV),
    .i_enable (r_state == WAIT),
    .o_expired(w_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_adc_res <= '0;
      r_op      <= OP0;
      r_switch  <= SW_HON;
      r_error   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_adc_res <= w_adc_res_nxt;
      r_op      <= w_op_nxt;
      r_switch  <= w_switch_nxt;
      r_error   <= w_error_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_adc_res_nxt = r_adc_res;
    w_op_nxt      = r_op;
    w_switch_nxt  = r_switch;
    w_error_nxt   = r_error;
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          if (bus.op_cfg != OP_FAIL) begin
            w_op_nxt     = bus.op_cfg;
            w_switch_nxt = SW_HON;
            w_error_nxt  = 1'b0;
            w_state_nxt  = CONV;
          end else begin
            w_op_nxt    = OP_FAIL;
            w_error_nxt = 1'b1;
            w_state_nxt = ERR;
          end
        end
      end
      CONV: w_state_nxt = WAIT;
      WAIT: begin
        // When a conversion result and the timeout arrive in the same cycle, the result is used.
        if (bus.adc_done) begin
          w_adc_res_nxt = bus.adc_data;
          w_state_nxt   = LOAD;
        end else if (w_expired) begin
          w_op_nxt    = OP_FAIL;
          w_error_nxt = 1'b1;
          w_state_nxt = ERR;
        end
      end
      LOAD: w_state_nxt = HOLD;
      // conc_logic samples on valid delayed by one clk, so the bus stays unchanged for one more cycle.
      HOLD: begin
        if (r_switch == SW_DT) begin
          w_state_nxt = DONE;
        end else begin
          w_switch_nxt = r_switch + 2'd1;
          w_state_nxt  = CONV;
        end
      end
      DONE: w_state_nxt = IDLE;
      // OP_FAIL is shown for exactly one cycle so that conc_logic reverts to its defaults. The op code is then cleared.
      ERR: begin
        w_op_nxt    = OP0;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.adc_start = (r_state == CONV);
  assign bus.valid     = (r_state == LOAD);
  assign bus.done      = (r_state == DONE);
  assign bus.busy      = (r_state != IDLE);
  assign bus.ADC_res   = r_adc_res;
  assign bus.op        = r_op;
  assign bus.switch    = r_switch;
  assign bus.error     = r_error;

endmodule

// File: tb/tb_dc_param_sequencer.sv
// Directed bench for dc_param_sequencer. It covers a normal load, a zero-wait load, timeout, a fail op, ignored stimulus and reset mid-sequence.
// Latency: n/a.
// Backpressure: n/a.
module tb_dc_param_sequencer;
  import dc_seq_pkg::*;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  dc_param_sequencer_if #(.ADC_width(8)) bus ();

  dc_param_sequencer #(.ADC_width(8), .TO_CYCLES(255)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered in the CONV cycle of a field. The ADC answers w cycles after adc_start.
  // When noise is set, a start pulse is sent during WAIT and a stray adc_done during HOLD.
  // Returns in the cycle after HOLD, which is CONV of the next field or DONE.
  task automatic run_field(input int w, input logic [7:0] data, input logic [1:0] sw,
                           input logic [2:0] opx, input bit noise);
    chk("fld_adc_start", bus.adc_start, 1);
    chk("fld_sw_conv", bus.switch, sw);
    step();
    if (noise) begin
      bus.start  = 1'b1;
      bus.op_cfg = OP6;
    end
    for (int k = 1; k < w; k++) begin
      step();
      bus.start = 1'b0;
    end
    chk("fld_wait_valid", bus.valid, 0);
    bus.adc_done = 1'b1;
    bus.adc_data = data;
    step();
    bus.adc_done = 1'b0;
    bus.start    = 1'b0;
    chk("fld_load_valid", bus.valid, 1);
    chk("fld_load_sw", bus.switch, sw);
    chk("fld_load_res", bus.ADC_res, data);
    chk("fld_load_op", bus.op, opx);
    chk("fld_load_done", bus.done, 0);
    step();
    if (noise) begin
      bus.adc_done = 1'b1;
      bus.adc_data = 8'hEE;
    end
    chk("fld_hold_valid", bus.valid, 0);
    chk("fld_hold_sw", bus.switch, sw);
    chk("fld_hold_res", bus.ADC_res, data);
    step();
    bus.adc_done = 1'b0;
    chk("fld_after_res", bus.ADC_res, data);
    chk("fld_after_op", bus.op, opx);
  endtask

  task automatic full_load(input logic [2:0] opx, input bit noise);
    bus.op_cfg = opx;
    bus.start  = 1'b1;
    step();
    bus.start  = 1'b0;
    chk("ld_busy", bus.busy, 1);
    chk("ld_err_clr", bus.error, 0);
    run_field(3, 8'h11, SW_HON, opx, noise);
    run_field(3, 8'h22, SW_LON, opx, noise);
    run_field(3, 8'h33, SW_DT,  opx, noise);
    chk("ld_done", bus.done, 1);
    chk("ld_done_busy", bus.busy, 1);
    step();
    chk("ld_done_pulse", bus.done, 0);
    chk("ld_idle_busy", bus.busy, 0);
    chk("ld_idle_start", bus.adc_start, 0);
    chk("ld_keep_sw", bus.switch, SW_DT);
    chk("ld_keep_res", bus.ADC_res, 8'h33);
    chk("ld_keep_op", bus.op, opx);
  endtask

  initial begin
    int  n;
    bit  prev;
    bit  got;
    rst = 1'b0;
    bus.start = 1'b0; bus.op_cfg = 3'b000; bus.adc_done = 1'b0; bus.adc_data = 8'h00;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_res", bus.ADC_res, 0);
    chk("rst_op", bus.op, 0);
    chk("rst_sw", bus.switch, 0);
    chk("rst_valid", bus.valid, 0);
    chk("rst_adc_start", bus.adc_start, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_error", bus.error, 0);
    rst = 1'b0;
    step();

    // Normal load with op 010 and 3-cycle ADC latency.
    full_load(OP2, 1'b0);

    // Zero-wait ADC: done is expected 13 clk after the start cycle.
    bus.op_cfg = OP5;
    bus.start  = 1'b1;
    n = 0; prev = 1'b0; got = 1'b0;
    while (!got && n < 40) begin
      step();
      bus.start    = 1'b0;
      n++;
      bus.adc_done = prev;
      bus.adc_data = 8'h40 + 8'(n);
      prev         = bus.adc_start;
      got          = bus.done;
    end
    bus.adc_done = 1'b0;
    chk("zw_done_seen", got, 1);
    chk("zw_latency", n, 13);
    chk("zw_res", bus.ADC_res, 8'h4A);
    step();
    chk("zw_idle", bus.busy, 0);

    // Timeout on field 2: the ADC stays silent.
    bus.op_cfg = OP1;
    bus.start  = 1'b1;
    step();
    bus.start  = 1'b0;
    run_field(1, 8'hA1, SW_HON, OP1, 1'b0);
    chk("to_conv2", bus.adc_start, 1);
    repeat (256) step();
    chk("to_wait_err", bus.error, 0);
    chk("to_wait_busy", bus.busy, 1);
    chk("to_wait_op", bus.op, OP1);
    step();
    chk("to_err_error", bus.error, 1);
    chk("to_err_op", bus.op, OP_FAIL);
    chk("to_err_busy", bus.busy, 1);
    step();
    chk("to_idle_op", bus.op, OP0);
    chk("to_idle_busy", bus.busy, 0);
    chk("to_idle_error", bus.error, 1);
    chk("to_idle_valid", bus.valid, 0);

    // The next start clears error. adc_done on the last timer cycle is still accepted.
    bus.op_cfg = OP3;
    bus.start  = 1'b1;
    step();
    bus.start  = 1'b0;
    chk("rs_err_clr", bus.error, 0);
    run_field(256, 8'hBB, SW_HON, OP3, 1'b0);
    run_field(1, 8'hCC, SW_LON, OP3, 1'b0);
    run_field(1, 8'hDD, SW_DT,  OP3, 1'b0);
    chk("rs_done", bus.done, 1);
    chk("rs_error", bus.error, 0);
    step();

    // A start with the fail op code goes straight to ERR.
    bus.op_cfg = OP_FAIL;
    bus.start  = 1'b1;
    step();
    bus.start  = 1'b0;
    chk("fo_adc_start", bus.adc_start, 0);
    chk("fo_error", bus.error, 1);
    chk("fo_op", bus.op, OP_FAIL);
    chk("fo_busy", bus.busy, 1);
    step();
    chk("fo_op_clr", bus.op, OP0);
    chk("fo_error_stk", bus.error, 1);
    chk("fo_busy_clr", bus.busy, 0);
    chk("fo_adc_start2", bus.adc_start, 0);

    // A start pulse while busy and a stray adc_done in HOLD must both be ignored.
    full_load(OP2, 1'b1);

    // Reset asserted during WAIT of field 2.
    bus.op_cfg = OP2;
    bus.start  = 1'b1;
    step();
    bus.start  = 1'b0;
    run_field(3, 8'h11, SW_HON, OP2, 1'b0);
    step();
    #2 rst = 1'b1;
    #1;
    chk("mr_res", bus.ADC_res, 0);
    chk("mr_op", bus.op, 0);
    chk("mr_sw", bus.switch, 0);
    chk("mr_valid", bus.valid, 0);
    chk("mr_adc_start", bus.adc_start, 0);
    chk("mr_busy", bus.busy, 0);
    chk("mr_done", bus.done, 0);
    chk("mr_error", bus.error, 0);
    #2 rst = 1'b0;
    step();
    bus.adc_done = 1'b1;
    bus.adc_data = 8'h77;
    step();
    bus.adc_done = 1'b0;
    chk("mr_idle_busy", bus.busy, 0);
    chk("mr_idle_res", bus.ADC_res, 0);
    bus.op_cfg = OP4;
    bus.start  = 1'b1;
    step();
    bus.start  = 1'b0;
    chk("mr_restart", bus.adc_start, 1);
    chk("mr_restart_op", bus.op, OP4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
